// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } pc_state_e;

  localparam int          INSTR_BYTES          = 4;
  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // Instructions are word aligned, so any set bit in the low two bits is a fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW-1:0]   next_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            pop_ok;

  assign next_ptr = top_ptr + PW'(1);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign top      = mem[top_ptr];

  // A simultaneous push and pop replaces the top in place, leaving depth unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (en) begin
      if (push && pop_ok) begin
        top_ptr <= top_ptr;
      end else if (push) begin
        top_ptr <= next_ptr;
        if (!full) count <= count + CW'(1);
      end else if (pop_ok) begin
        top_ptr <= top_ptr - PW'(1);
        count   <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (push && pop_ok) begin
        mem[top_ptr] <= push_addr;
      end else if (push) begin
        mem[next_ptr] <= push_addr;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall, trap entry/return, double-fault halt.
// Define PC_RAS_EN to build the optional return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic            trap_ret,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] epc,
  output logic            in_handler,
  output logic            halted,
  output logic            misalign,
  output logic            ras_empty
);

  pc_state_e       state, state_next;
  logic [XLEN-1:0] pc_next, epc_next;
  logic            misalign_next;
  logic            br_misaligned;
  logic            trap_entry;
  logic [XLEN-1:0] ras_top;
  logic            ras_is_empty;

  assign br_misaligned = br_taken & is_misaligned(br_target[1:0]);
  assign trap_entry    = trap_req | br_misaligned;

`ifdef PC_RAS_EN
  // The stack keeps tracking calls/returns even when a higher-priority redirect wins.
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .en        (state != HALT),
    .push      (ras_push),
    .push_addr (ras_push_addr),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_is_empty)
  );
`else
  wire unused_ras = ^{ras_push, ras_push_addr, RAS_DEPTH[0]};
  assign ras_top      = '0;
  assign ras_is_empty = 1'b1;
`endif

  assign ras_empty  = ras_is_empty;
  assign in_handler = (state == HANDLER);
  assign halted     = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_out   <= RESET_VECTOR;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      epc      <= epc_next;
      misalign <= misalign_next;
    end
  end

  // A trap taken inside the handler escalates to HALT and keeps the first epc.
  always_comb begin
    state_next    = state;
    pc_next       = pc_out;
    epc_next      = epc;
    misalign_next = 1'b0;
    if (state != HALT) begin
      if (trap_entry) begin
        pc_next       = TRAP_VECTOR;
        misalign_next = br_misaligned;
        if (state == RUN) begin
          state_next = HANDLER;
          epc_next   = pc_out;
        end else begin
          state_next = HALT;
        end
      end else if (trap_ret && state == HANDLER) begin
        pc_next    = epc;
        state_next = RUN;
      end else if (br_taken) begin
        pc_next = br_target;
      end else if (ras_pop && !ras_is_empty) begin
        pc_next = ras_top;
      end else if (!stall) begin
        pc_next = pc_out + XLEN'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a queue-based model.
module tb_pc_gen;

  localparam int          XLEN      = 32;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RV        = 32'h0;
  localparam logic [31:0] TV        = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, trap_req, trap_ret, ras_push, ras_pop;
  logic [31:0] br_target, ras_push_addr;
  logic [31:0] pc_out, epc;
  logic        in_handler, halted, misalign, ras_empty;

  int tests    = 0;
  int failures = 0;

  // Reference model: mode 0 = running, 1 = in handler, 2 = halted
  logic [31:0] m_pc, m_epc;
  int          m_mode;
  logic        m_mis;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .trap_req      (trap_req),
    .trap_ret      (trap_ret),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .pc_out        (pc_out),
    .epc           (epc),
    .in_handler    (in_handler),
    .halted        (halted),
    .misalign      (misalign),
    .ras_empty     (ras_empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelStep();
    bit          ras_on;
    bit          pop_ok;
    logic [31:0] old_top;
`ifdef PC_RAS_EN
    ras_on = 1'b1;
`else
    ras_on = 1'b0;
`endif
    if (rst) begin
      m_pc = RV; m_epc = 0; m_mode = 0; m_mis = 0;
      m_ras.delete();
      return;
    end
    m_mis = 0;
    if (m_mode == 2) return;
    pop_ok  = ras_on && ras_pop && m_ras.size() > 0;
    old_top = pop_ok ? m_ras[m_ras.size()-1] : 32'h0;
    if (trap_req || (br_taken && br_target[1:0] != 0)) begin
      m_mis = br_taken && br_target[1:0] != 0;
      if (m_mode == 0) begin
        m_epc  = m_pc;
        m_mode = 1;
      end else begin
        m_mode = 2;
      end
      m_pc = TV;
    end else if (trap_ret && m_mode == 1) begin
      m_pc = m_epc; m_mode = 0;
    end else if (br_taken) begin
      m_pc = br_target;
    end else if (pop_ok) begin
      m_pc = old_top;
    end else if (!stall) begin
      m_pc = m_pc + 4;
    end
    if (ras_on) begin
      if (ras_push && pop_ok) begin
        m_ras[m_ras.size()-1] = ras_push_addr;
      end else if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (pop_ok) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic br, input logic [31:0] tgt,
                               input logic tq, input logic tr, input logic ps,
                               input logic [31:0] pa, input logic pp);
    @(negedge clk);
    rst = r; stall = st; br_taken = br; br_target = tgt; trap_req = tq; trap_ret = tr;
    ras_push = ps; ras_push_addr = pa; ras_pop = pp;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput("pc_out", pc_out, m_pc);
    checkOutput("epc", epc, m_epc);
    checkOutput("in_handler", {31'b0, in_handler}, {31'b0, m_mode == 1});
    checkOutput("halted", {31'b0, halted}, {31'b0, m_mode == 2});
    checkOutput("misalign", {31'b0, misalign}, {31'b0, m_mis});
`ifdef PC_RAS_EN
    checkOutput("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
`else
    checkOutput("ras_empty", {31'b0, ras_empty}, 32'h1);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic branch(input logic [31:0] tgt, input logic st);
    applyStimulus(0, st, 1, tgt, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; stall = 0; br_taken = 0; br_target = 0; trap_req = 0; trap_ret = 0;
    ras_push = 0; ras_push_addr = 0; ras_pop = 0;
    m_pc = 0; m_epc = 0; m_mode = 0; m_mis = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_pc", pc_out, 32'h0);
    idle(3);
    checkOutput("idle_pc12", pc_out, 32'hC);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_hold", pc_out, 32'hC);
    idle(1);
    checkOutput("stall_release", pc_out, 32'h10);

    branch(32'h40, 1);
    checkOutput("branch_over_stall", pc_out, 32'h40);
    branch(32'h42, 0);
    checkOutput("misalign_pc", pc_out, TV);
    checkOutput("misalign_epc", epc, 32'h40);
    checkOutput("misalign_pulse", {31'b0, misalign}, 32'h1);
    idle(1);
    checkOutput("misalign_drop", {31'b0, misalign}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);

    branch(32'h20, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("trap_epc", epc, 32'h20);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mret_pc", pc_out, 32'h20);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mret_in_run", pc_out, 32'h24);

    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("double_fault", {31'b0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) branch(32'h80, 0);
    checkOutput("halt_frozen", pc_out, TV);
    checkOutput("halt_epc", epc, 32'h24);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_reset", pc_out, RV);

`ifdef PC_RAS_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hB0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ras_pop1", pc_out, 32'hB0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ras_pop2", pc_out, 32'hA0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ras_pop_empty", pc_out, 32'hA4);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'(i * 16), 0);
    for (int i = 5; i >= 2; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("ras_overwrite", pc_out, 32'(i * 16));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hC0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hD0, 1);
    checkOutput("ras_push_pop", pc_out, 32'hC0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ras_replaced_top", pc_out, 32'hD0);
`endif

    branch(32'hFFFF_FFFC, 0);
    idle(1);
    checkOutput("pc_wrap", pc_out, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, tgt,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, {$urandom_range(0, 255), 2'b00},
                    $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
